// File: rtl/conv1d_par_stream.sv
// Run-time-loaded 1-D valid-mode convolution with P parallel saturating MAC lanes.
// Optional build macro CONV_RELU_EN clamps negative results to zero before the result RAM.
module conv1d_par_stream #(
  parameter int T      = 16,
  parameter int OUT_W  = 16,
  parameter int SIZE_X = 96,
  parameter int SIZE_F = 65,
  parameter int P      = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [T-1:0]     f_data,
  input  logic                    f_valid,
  output logic                    f_ready,
  input  logic signed [T-1:0]     x_data,
  input  logic                    x_valid,
  output logic                    x_ready,
  output logic signed [OUT_W-1:0] y_data,
  output logic                    y_valid,
  input  logic                    y_ready
);

  localparam int Y_PTS    = SIZE_X - SIZE_F + 1;
  localparam int NPASS    = (Y_PTS + P - 1) / P;
  localparam int PIPE     = 3;
  localparam int PASS_LEN = SIZE_F + PIPE;
  localparam int AW       = ((2 * T > OUT_W) ? 2 * T : OUT_W) + 2;
  localparam int XIW      = (SIZE_X > 1) ? $clog2(SIZE_X) : 1;
  localparam int FIW      = (SIZE_F > 1) ? $clog2(SIZE_F) : 1;
  localparam int RIW      = (NPASS * P > 1) ? $clog2(NPASS * P) : 1;
  localparam int XCW      = $clog2(SIZE_X + 1);
  localparam int FCW      = $clog2(SIZE_F + 1);
  localparam int KW       = $clog2(PASS_LEN);
  localparam int PW       = $clog2(NPASS + 1);
  localparam int OIW      = $clog2(Y_PTS + 1);

  localparam logic signed [AW-1:0] SAT_MAX = {{(AW-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {S_LOAD, S_COMPUTE, S_FETCH, S_OUTPUT} state_t;

  state_t                  r_state;
  logic                    r_fReady, r_xReady, r_fLoaded, r_xFull;
  logic [FCW-1:0]          r_fCnt;
  logic [XCW-1:0]          r_xCnt;
  logic [KW-1:0]           r_k;
  logic [PW-1:0]           r_pass;
  logic                    r_v1, r_v2;
  logic signed [T-1:0]     r_fTap;
  logic signed [T-1:0]     r_xTap [P];
  logic signed [OUT_W-1:0] r_prod [P];
  logic signed [OUT_W-1:0] r_acc  [P];
  logic signed [OUT_W-1:0] r_yData;
  logic                    r_yValid;
  logic [OIW-1:0]          r_outIdx;

  logic signed [T-1:0]     r_fMem [SIZE_F];
  logic signed [T-1:0]     r_xMem [SIZE_X];
  logic signed [OUT_W-1:0] r_res  [NPASS*P];

  logic                    w_fTake, w_xTake, w_passEnd;
  logic                    w_laneEn  [P];
  logic signed [T-1:0]     w_xSel    [P];
  logic signed [OUT_W-1:0] w_resVal  [P];
  logic signed [T-1:0]     w_fSel;

  function automatic logic signed [OUT_W-1:0] satW(input logic signed [AW-1:0] v);
    if (v > SAT_MAX) return SAT_MAX[OUT_W-1:0];
    else if (v < SAT_MIN) return SAT_MIN[OUT_W-1:0];
    else return v[OUT_W-1:0];
  endfunction

  assign f_ready   = r_fReady;
  assign x_ready   = r_xReady;
  assign y_data    = r_yData;
  assign y_valid   = r_yValid;
  assign w_fTake   = f_valid && r_fReady;
  assign w_xTake   = x_valid && r_xReady;
  assign w_passEnd = (r_state == S_COMPUTE) && (r_k == KW'(PASS_LEN - 1));

  // Lanes past Y_PTS in the last pass may index beyond x; they read zero and never write back.
  always_comb begin
    w_fSel = '0;
    if (r_k < KW'(SIZE_F)) w_fSel = r_fMem[FIW'(r_k)];
    for (int i = 0; i < P; i++) begin
      w_laneEn[i] = (int'(r_pass) * P + i) < Y_PTS;
      w_xSel[i]   = '0;
      if ((int'(r_pass) * P + i + int'(r_k)) < SIZE_X)
        w_xSel[i] = r_xMem[XIW'(int'(r_pass) * P + i + int'(r_k))];
`ifdef CONV_RELU_EN
      w_resVal[i] = r_acc[i][OUT_W-1] ? '0 : r_acc[i];
`else
      w_resVal[i] = r_acc[i];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (w_fTake) r_fMem[FIW'(r_fCnt)] <= f_data;
    if (w_xTake) r_xMem[XIW'(r_xCnt)] <= x_data;
    if (w_passEnd)
      for (int i = 0; i < P; i++)
        if (w_laneEn[i]) r_res[RIW'(int'(r_pass) * P + i)] <= w_resVal[i];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_LOAD;
      r_fReady  <= 1'b1;
      r_xReady  <= 1'b1;
      r_fLoaded <= 1'b0;
      r_xFull   <= 1'b0;
      r_fCnt    <= '0;
      r_xCnt    <= '0;
      r_k       <= '0;
      r_pass    <= '0;
      r_v1      <= 1'b0;
      r_v2      <= 1'b0;
      r_fTap    <= '0;
      r_yData   <= '0;
      r_yValid  <= 1'b0;
      r_outIdx  <= '0;
      for (int i = 0; i < P; i++) begin
        r_xTap[i] <= '0;
        r_prod[i] <= '0;
        r_acc[i]  <= '0;
      end
    end else begin
      if (w_fTake) begin
        r_fCnt <= r_fCnt + 1'b1;
        if (r_fCnt == FCW'(SIZE_F - 1)) begin
          r_fReady  <= 1'b0;
          r_fLoaded <= 1'b1;
        end
      end
      if (w_xTake) begin
        r_xCnt <= r_xCnt + 1'b1;
        if (r_xCnt == XCW'(SIZE_X - 1)) begin
          r_xReady <= 1'b0;
          r_xFull  <= 1'b1;
        end
      end

      // Three-stage MAC: operand fetch, saturated product, saturated accumulate.
      r_v1   <= (r_state == S_COMPUTE) && (r_k < KW'(SIZE_F));
      r_v2   <= r_v1;
      r_fTap <= w_fSel;
      for (int i = 0; i < P; i++) begin
        r_xTap[i] <= w_xSel[i];
        r_prod[i] <= satW(AW'(r_fTap) * AW'(r_xTap[i]));
        if (r_v2) r_acc[i] <= satW(AW'(r_acc[i]) + AW'(r_prod[i]));
      end

      case (r_state)
        S_LOAD: begin
          if (r_xFull && r_fLoaded) begin
            r_state <= S_COMPUTE;
            r_k     <= '0;
            r_pass  <= '0;
          end
        end
        S_COMPUTE: begin
          if (w_passEnd) begin
            r_k <= '0;
            for (int i = 0; i < P; i++) r_acc[i] <= '0;
            if (r_pass == PW'(NPASS - 1)) r_state <= S_FETCH;
            else r_pass <= r_pass + 1'b1;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        S_FETCH: begin
          r_yData  <= r_res[0];
          r_yValid <= 1'b1;
          r_outIdx <= OIW'(1);
          r_state  <= S_OUTPUT;
        end
        S_OUTPUT: begin
          if (y_ready) begin
            if (r_outIdx == OIW'(Y_PTS)) begin
              r_yValid <= 1'b0;
              r_state  <= S_LOAD;
              r_xReady <= 1'b1;
              r_xCnt   <= '0;
              r_xFull  <= 1'b0;
            end else begin
              r_yData  <= r_res[RIW'(r_outIdx)];
              r_outIdx <= r_outIdx + 1'b1;
            end
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_conv1d_par_stream.sv
// Directed bench for conv1d_par_stream with a queue scoreboard fed by a saturating reference model.
module tb_conv1d_par_stream;

  localparam int T      = 16;
  localparam int OUT_W  = 16;
  localparam int SIZE_X = 8;
  localparam int SIZE_F = 3;
  localparam int P      = 4;
  localparam int Y_PTS  = SIZE_X - SIZE_F + 1;
  localparam int NPASS  = (Y_PTS + P - 1) / P;
  localparam int LAT    = NPASS * (SIZE_F + 3) + 2;

  logic                    clk = 1'b0;
  logic                    reset;
  logic signed [T-1:0]     f_data, x_data;
  logic                    f_valid, f_ready, x_valid, x_ready;
  logic signed [OUT_W-1:0] y_data;
  logic                    y_valid, y_ready;

  int checks   = 0;
  int errors   = 0;
  int gotCount = 0;
  int expQ[$];
  int fv[SIZE_F];
  int xv[SIZE_X];

  conv1d_par_stream #(.T(T), .OUT_W(OUT_W), .SIZE_X(SIZE_X), .SIZE_F(SIZE_F), .P(P)) dut (
    .clk(clk), .reset(reset),
    .f_data(f_data), .f_valid(f_valid), .f_ready(f_ready),
    .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
    .y_data(y_data), .y_valid(y_valid), .y_ready(y_ready)
  );

  always #5 clk = ~clk;

  function automatic int sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Reference model: saturate each product, then each partial sum.
  task automatic pushExpected();
    int acc;
    for (int j = 0; j < Y_PTS; j++) begin
      acc = 0;
      for (int k = 0; k < SIZE_F; k++)
        acc = sat16(longint'(acc) + longint'(sat16(longint'(fv[k]) * longint'(xv[j+k]))));
`ifdef CONV_RELU_EN
      if (acc < 0) acc = 0;
`endif
      expQ.push_back(acc);
    end
  endtask

  task automatic applyStimulus(input bit withF);
    pushExpected();
    if (withF) begin
      checkOutput("f_ready_pre", int'(f_ready), 1);
      for (int k = 0; k < SIZE_F; k++) begin
        f_data = 16'(fv[k]); f_valid = 1'b1;
        @(posedge clk); #1;
      end
      f_valid = 1'b0;
      checkOutput("f_ready_drop", int'(f_ready), 0);
    end else begin
      checkOutput("f_ready_idle", int'(f_ready), 0);
    end
    checkOutput("x_ready_pre", int'(x_ready), 1);
    for (int k = 0; k < SIZE_X; k++) begin
      x_data = 16'(xv[k]); x_valid = 1'b1;
      @(posedge clk); #1;
    end
    x_valid = 1'b0;
    checkOutput("x_ready_drop", int'(x_ready), 0);
  endtask

  task automatic drainOutputs(input bit stall);
    int n, base;
    bit stalled;
    base = gotCount;
    n = 0;
    while (!y_valid && n < 200) begin @(posedge clk); #1; n++; end
    checkOutput("latency", n, LAT);
    n = 0;
    stalled = 1'b0;
    while ((gotCount - base) < Y_PTS && n < 500) begin
      if (stall && !stalled && (gotCount - base) == 2 && y_valid) begin
        stalled = 1'b1;
        y_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          checkOutput("stall_data", int'($signed(y_data)), expQ[0]);
          checkOutput("stall_valid", int'(y_valid), 1);
        end
        @(posedge clk); #1;
        y_ready = 1'b1;
      end
      @(posedge clk); #1; n++;
    end
    checkOutput("y_count", gotCount - base, Y_PTS);
    checkOutput("x_ready_after", int'(x_ready), 1);
    checkOutput("y_valid_after", int'(y_valid), 0);
    checkOutput("queue_empty", expQ.size(), 0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    expQ.delete();
  endtask

  // Scoreboard side: every accepted output pops one expectation.
  always @(negedge clk) begin
    if (y_valid === 1'b1 && y_ready === 1'b1) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $error("[TB] FAIL y_unexpected observed=%0d expected=none", $signed(y_data));
      end else begin
        checkOutput("y_data", int'($signed(y_data)), expQ.pop_front());
      end
      gotCount++;
    end
  end

  initial begin
    reset = 1'b1; f_valid = 1'b0; x_valid = 1'b0;
    f_data = '0; x_data = '0; y_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    checkOutput("reset_f_ready", int'(f_ready), 1);
    checkOutput("reset_x_ready", int'(x_ready), 1);
    checkOutput("reset_y_valid", int'(y_valid), 0);
    checkOutput("reset_y_data", int'($signed(y_data)), 0);

    $display("[TB] basic box filter");
    fv = '{1, 1, 1};
    for (int i = 0; i < SIZE_X; i++) xv[i] = i + 1;
    applyStimulus(1'b1);
    drainOutputs(1'b0);

    $display("[TB] backpressure on third output");
    applyStimulus(1'b0);
    drainOutputs(1'b1);

    $display("[TB] second vector reuses taps");
    for (int i = 0; i < SIZE_X; i++) xv[i] = i + 2;
    applyStimulus(1'b0);
    drainOutputs(1'b0);

    $display("[TB] negative taps");
    doReset();
    fv = '{-1, 0, 0};
    for (int i = 0; i < SIZE_X; i++) xv[i] = i + 1;
    applyStimulus(1'b1);
    drainOutputs(1'b0);

    $display("[TB] positive saturation");
    doReset();
    fv = '{32767, 32767, 32767};
    for (int i = 0; i < SIZE_X; i++) xv[i] = 32767;
    applyStimulus(1'b1);
    drainOutputs(1'b0);

    $display("[TB] negative saturation");
    doReset();
    for (int i = 0; i < SIZE_X; i++) xv[i] = -32768;
    applyStimulus(1'b1);
    drainOutputs(1'b0);

    $display("[TB] reset during compute");
    doReset();
    fv = '{1, 1, 1};
    for (int i = 0; i < SIZE_X; i++) xv[i] = i + 1;
    applyStimulus(1'b1);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    expQ.delete();
    checkOutput("midreset_x_ready", int'(x_ready), 1);
    checkOutput("midreset_f_ready", int'(f_ready), 1);
    checkOutput("midreset_y_valid", int'(y_valid), 0);
    applyStimulus(1'b1);
    drainOutputs(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
